// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port with a ready handshake.
// The core drives the request side; memory answers with ready and read data.
interface mips_multicycle_core_if #(
  parameter int unsigned DATA_WIDTH_P = 32
);
  logic                    o_mem_req;
  logic                    o_mem_we;
  logic [DATA_WIDTH_P-1:0] o_mem_addr;
  logic [DATA_WIDTH_P-1:0] o_mem_wdata;
  logic [DATA_WIDTH_P-1:0] i_mem_rdata;
  logic                    i_mem_ready;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ready
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw, beq, j) on one
// shared wait-state-tolerant memory port; any other encoding traps until reset.
module mips_multicycle_core #(
  parameter int unsigned                  DATA_WIDTH_P  = 32,
  parameter int unsigned                  ADDR_WIDTH_P  = 5,
  parameter logic [DATA_WIDTH_P-1:0]      RESET_PC_P    = '0,
  parameter int unsigned                  OP_WIDTH_P    = 6,
  parameter int unsigned                  FUNCT_WIDTH_P = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_core_if.master  mem,
  output logic [DATA_WIDTH_P-1:0] o_pc,
  output logic                    o_retire,
  output logic                    o_trap
);

  localparam int unsigned DW   = DATA_WIDTH_P;
  localparam int unsigned NREG = 1 << ADDR_WIDTH_P;

  localparam logic [OP_WIDTH_P-1:0]    OP_RTYPE = OP_WIDTH_P'(32'h00);
  localparam logic [OP_WIDTH_P-1:0]    OP_ADDI  = OP_WIDTH_P'(32'h08);
  localparam logic [OP_WIDTH_P-1:0]    OP_LW    = OP_WIDTH_P'(32'h23);
  localparam logic [OP_WIDTH_P-1:0]    OP_SW    = OP_WIDTH_P'(32'h2B);
  localparam logic [OP_WIDTH_P-1:0]    OP_BEQ   = OP_WIDTH_P'(32'h04);
  localparam logic [OP_WIDTH_P-1:0]    OP_J     = OP_WIDTH_P'(32'h02);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_ADD   = FUNCT_WIDTH_P'(32'h20);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_SUB   = FUNCT_WIDTH_P'(32'h22);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_AND   = FUNCT_WIDTH_P'(32'h24);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_OR    = FUNCT_WIDTH_P'(32'h25);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_SLT   = FUNCT_WIDTH_P'(32'h2A);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  state_e                  state_q, state_d;
  logic [DW-1:0]           pc_q, pc_d;
  logic [DW-1:0]           ir_q, a_q, b_q, imm_q, tgt_q, res_q;
  logic [ADDR_WIDTH_P-1:0] dest_q;
  logic [DW-1:0]           rf_q [NREG];

  logic                    req_q, req_d, we_q, we_d, trap_q, trap_d;
  logic [DW-1:0]           addr_q, addr_d, wdata_q, wdata_d;

  logic [OP_WIDTH_P-1:0]    op;
  logic [FUNCT_WIDTH_P-1:0] funct;
  logic [ADDR_WIDTH_P-1:0]  rs, rt, rd;
  logic [DW-1:0]            sext_imm, jump_pc, alu_r;
  logic                     funct_ok, ready;

  assign ready    = mem.i_mem_ready;
  assign op       = ir_q[31 -: OP_WIDTH_P];
  assign funct    = ir_q[FUNCT_WIDTH_P-1:0];
  assign rs       = ADDR_WIDTH_P'(ir_q[25:21]);
  assign rt       = ADDR_WIDTH_P'(ir_q[20:16]);
  assign rd       = ADDR_WIDTH_P'(ir_q[15:11]);
  assign sext_imm = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_pc  = {pc_q[DW-1:26], ir_q[25:0]};
  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    alu_r = '0;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = ($signed(a_q) < $signed(b_q)) ? DW'(1) : '0;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = funct_ok ? S_EXEC_R : S_TRAP;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I:       state_d = S_WB;
      S_MEM_ADDR:               state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:                 if (ready) state_d = S_WB;
      S_MEM_WR:                 if (ready) state_d = S_FETCH;
      S_WB, S_BRANCH, S_JUMP:   state_d = S_FETCH;
      S_TRAP:                   state_d = S_TRAP;
      default:                  state_d = S_RST;
    endcase
  end

  // Memory outputs are registered from the next state so they are valid the
  // first cycle of FETCH/MEM_* and stay frozen across wait-states.
  always_comb begin
    req_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    trap_d   = 1'b0;
    o_retire = 1'b0;
    case (state_d)
      S_FETCH:  begin req_d = 1'b1; addr_d = pc_d; end
      S_MEM_RD: begin req_d = 1'b1; addr_d = a_q + imm_q; end
      S_MEM_WR: begin req_d = 1'b1; we_d = 1'b1; addr_d = a_q + imm_q; wdata_d = b_q; end
      S_TRAP:   trap_d = 1'b1;
      default:  ;
    endcase
    case (state_q)
      S_WB, S_BRANCH, S_JUMP: o_retire = 1'b1;
      S_MEM_WR:               o_retire = ready;
      default:                o_retire = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_FETCH:  if (ready) pc_d = pc_q + DW'(1);
      S_BRANCH: if (a_q == b_q) pc_d = tgt_q;
      S_JUMP:   pc_d = jump_pc;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC_P;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      tgt_q  <= '0;
      res_q  <= '0;
      dest_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_FETCH:  if (ready) ir_q <= mem.i_mem_rdata;
        S_DECODE: begin
          a_q   <= rf_q[rs];
          b_q   <= rf_q[rt];
          imm_q <= sext_imm;
          tgt_q <= pc_q + sext_imm;
        end
        S_EXEC_R: begin res_q <= alu_r;       dest_q <= rd; end
        S_EXEC_I: begin res_q <= a_q + imm_q; dest_q <= rt; end
        S_MEM_RD: if (ready) begin res_q <= mem.i_mem_rdata; dest_q <= rt; end
        S_WB:     if (dest_q != '0) rf_q[dest_q] <= res_q;
        default:  ;
      endcase
    end
  end

  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
  assign o_pc            = pc_q;
  assign o_trap          = trap_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small wait-state memory model,
// retire-cycle logger and hand-computed expectations.
module tb_mips_multicycle_core;
  localparam int unsigned DW  = 32;
  localparam logic [31:0] RPC = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] o_pc;
  logic        o_retire, o_trap;
  logic        rdy = 1'b0;

  mips_multicycle_core_if #(.DATA_WIDTH_P(DW)) mif ();

  mips_multicycle_core #(.DATA_WIDTH_P(DW), .RESET_PC_P(RPC)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (mif.master),
    .o_pc     (o_pc),
    .o_retire (o_retire),
    .o_trap   (o_trap)
  );

  always #5 clk = ~clk;

  // Memory: 256 words aliased on addr[7:0], ws wait-states per access.
  logic [31:0] mem [0:255];
  int unsigned ws = 0, ws_cnt = 0;
  assign mif.i_mem_rdata = mem[mif.o_mem_addr[7:0]];
  assign mif.i_mem_ready = rdy;

  always @(negedge clk) begin
    if (mif.o_mem_req) begin
      if (ws_cnt >= ws) begin rdy = 1'b1; ws_cnt = 0; end
      else begin rdy = 1'b0; ws_cnt++; end
    end else begin
      rdy = 1'b0; ws_cnt = 0;
    end
  end

  int          st_hold = 0, st_done = 0;
  logic        st_unstable = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  always @(posedge clk) begin
    if (mif.o_mem_req && mif.o_mem_we) begin
      if (st_hold == 0) begin st_addr = mif.o_mem_addr; st_data = mif.o_mem_wdata; end
      else if (mif.o_mem_addr != st_addr || mif.o_mem_wdata != st_data) st_unstable = 1'b1;
      st_hold++;
      if (rdy) begin mem[mif.o_mem_addr[7:0]] = mif.o_mem_wdata; st_done++; end
    end
  end

  // Retire log: cycle index 0 is the RST cycle after reset release.
  int cyc = 0;
  int ret_cyc[$];
  always @(posedge clk) begin
    if (reset) begin cyc = 0; ret_cyc.delete(); end
    else begin
      if (o_retire) ret_cyc.push_back(cyc);
      cyc++;
    end
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ret(input int n, input string tag);
    int k = 0;
    while (ret_cyc.size() < n && k < 400) begin tick(); k++; end
    chk(tag, 32'(ret_cyc.size()), 32'(n));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  initial begin
    logic bad;
    logic found;

    // ---- Phase A: addi/add, then sw/lw with 3 wait-states ----
    clear_mem();
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_FFFD;  // addi $2,$0,-3
    mem[2] = 32'h0022_1820;  // add  $3,$1,$2
    mem[3] = 32'hAC03_0010;  // sw   $3,0x10($0)
    mem[4] = 32'h8C04_0010;  // lw   $4,0x10($0)
    mem[5] = 32'h2000_0000;
    reset = 1'b1;
    tick(); tick();
    chk("rst_req",   32'(mif.o_mem_req),  32'h0);
    chk("rst_we",    32'(mif.o_mem_we),   32'h0);
    chk("rst_addr",  mif.o_mem_addr,      32'h0);
    chk("rst_wdata", mif.o_mem_wdata,     32'h0);
    chk("rst_retire",32'(o_retire),       32'h0);
    chk("rst_trap",  32'(o_trap),         32'h0);
    chk("rst_pc",    o_pc,                RPC);
    reset = 1'b0;
    tick();
    chk("fetch0_req",  32'(mif.o_mem_req), 32'h1);
    chk("fetch0_addr", mif.o_mem_addr,     RPC);

    wait_ret(3, "a_ret3");
    chk("a_ret_cyc0", 32'(ret_cyc[0]), 32'd4);
    chk("a_ret_cyc1", 32'(ret_cyc[1]), 32'd8);
    chk("a_ret_cyc2", 32'(ret_cyc[2]), 32'd12);
    chk("a_rf1", dut.rf_q[1], 32'd5);
    chk("a_rf2", dut.rf_q[2], 32'hFFFF_FFFD);
    chk("a_rf3", dut.rf_q[3], 32'd2);
    chk("a_pc3", o_pc, RPC + 32'd3);
    ws = 3; st_hold = 0; st_done = 0; st_unstable = 1'b0;

    wait_ret(5, "a_ret5");
    chk("sw_cycles",   32'(ret_cyc[3] - ret_cyc[2]), 32'd10);
    chk("lw_cycles",   32'(ret_cyc[4] - ret_cyc[3]), 32'd11);
    chk("sw_addr",     st_addr, 32'h10);
    chk("sw_data",     st_data, 32'd2);
    chk("sw_hold",     32'(st_hold), 32'd4);
    chk("sw_stable",   32'(st_unstable), 32'h0);
    chk("sw_done",     32'(st_done), 32'd1);
    chk("a_rf4",       dut.rf_q[4], 32'd2);

    // ---- Phase B: jump to 0x0BFF_FFFF, then illegal opcode traps ----
    reset = 1'b1; ws = 0;
    tick();
    clear_mem();
    mem[0]   = 32'h0BFF_FFFF;  // j 0x3FFFFFF
    mem[255] = 32'hFC00_0000;  // opcode 0x3F
    tick();
    reset = 1'b0;
    tick();
    wait_ret(1, "b_ret1");
    chk("j_cycles", 32'(ret_cyc[0]), 32'd3);
    chk("j_pc",     o_pc, 32'h0BFF_FFFF);
    tick(); tick(); tick();
    chk("trap_set", 32'(o_trap), 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mif.o_mem_req || o_retire || o_pc != 32'h0C00_0000) bad = 1'b1;
      tick();
    end
    chk("trap_quiet",  32'(bad),    32'h0);
    chk("trap_sticky", 32'(o_trap), 32'h1);
    chk("trap_pc",     o_pc,        32'h0C00_0000);

    // ---- Phase C: branches, ALU ops, wraparound, reset mid-MEM_RD ----
    reset = 1'b1;
    tick();
    chk("trap_clr", 32'(o_trap), 32'h0);
    clear_mem();
    mem[0]  = 32'h2001_0007;  // addi $1,$0,7
    mem[1]  = 32'h2002_0007;  // addi $2,$0,7
    mem[2]  = 32'h0800_0004;  // j    4
    mem[3]  = 32'h2002_0008;  // addi $2,$0,8
    mem[4]  = 32'h1022_FFFE;  // beq  $1,$2,-2
    mem[5]  = 32'h2005_FFFF;  // addi $5,$0,-1
    mem[6]  = 32'h00A5_2820;  // add  $5,$5,$5
    mem[7]  = 32'h0022_3022;  // sub  $6,$1,$2
    mem[8]  = 32'h0022_3825;  // or   $7,$1,$2
    mem[9]  = 32'h00A1_402A;  // slt  $8,$5,$1
    mem[10] = 32'h00A1_4824;  // and  $9,$5,$1
    mem[11] = 32'h2000_0009;  // addi $0,$0,9
    mem[12] = 32'h8C0B_0010;  // lw   $11,0x10($0)
    mem[16] = 32'h0000_BEEF;
    tick();
    reset = 1'b0;
    tick();
    chk("restart_addr", mif.o_mem_addr, RPC);
    chk("restart_req",  32'(mif.o_mem_req), 32'h1);

    wait_ret(4, "c_ret4");
    chk("beq_t_cycles", 32'(ret_cyc[3] - ret_cyc[2]), 32'd3);
    chk("beq_t_pc",     o_pc, RPC + 32'd3);
    wait_ret(6, "c_ret6");
    chk("beq_n_cycles", 32'(ret_cyc[5] - ret_cyc[4]), 32'd3);
    chk("beq_n_pc",     o_pc, RPC + 32'd5);
    wait_ret(13, "c_ret13");
    chk("c_rf2_wrap", dut.rf_q[2], 32'd8);
    chk("c_rf5_wrap", dut.rf_q[5], 32'hFFFF_FFFE);
    chk("c_rf6_sub",  dut.rf_q[6], 32'hFFFF_FFFF);
    chk("c_rf7_or",   dut.rf_q[7], 32'h0000_000F);
    chk("c_rf8_slt",  dut.rf_q[8], 32'h0000_0001);
    chk("c_rf9_and",  dut.rf_q[9], 32'h0000_0006);
    chk("c_rf0_zero", dut.rf_q[0], 32'h0);

    ws = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (mif.o_mem_req && !mif.o_mem_we && mif.o_mem_addr == 32'h10) found = 1'b1;
    end
    chk("mrd_seen", 32'(found), 32'h1);
    tick();
    chk("mrd_hold", 32'(mif.o_mem_req), 32'h1);
    reset = 1'b1;
    tick();
    chk("mrd_abort_req", 32'(mif.o_mem_req), 32'h0);
    chk("mrd_rf11",      dut.rf_q[11], 32'h0);
    chk("mrd_rf5_clr",   dut.rf_q[5],  32'h0);
    chk("mrd_pc",        o_pc, RPC);
    ws = 0;
    reset = 1'b0;
    tick();
    chk("resume_req",  32'(mif.o_mem_req), 32'h1);
    chk("resume_addr", mif.o_mem_addr, RPC);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
